// File: rtl/chan_select_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chan_select_loader_pkg
//  Description : Shared channelizer definitions used by the channel-select
//                mask loader: settings-bus addresses, mask depth, FSM state
//                encoding and the burst-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package chan_select_loader_pkg;

  // Settings-bus register map
  localparam logic [7:0] CHAN_SR_SELECT_ADDR   = 8'd134;
  localparam logic [7:0] CHAN_SR_SELECT_DATA   = 8'd135;
  localparam logic [7:0] CHAN_SR_SELECT_COMMIT = 8'd136;

  // Mask depth in 32-bit words (64 words = 2048 channels)
  localparam int CHAN_MAX_WORDS = 64;
  localparam int CHAN_WORD_W    = 32;

  // Loader FSM encoding
  typedef logic [1:0] sel_state_t;
  localparam sel_state_t ST_IDLE   = 2'd0;
  localparam sel_state_t ST_FETCH  = 2'd1;
  localparam sel_state_t ST_STREAM = 2'd2;

  // Number of mask words covering fft_size channels, clamped to [1, max_words].
  function automatic logic [15:0] calc_nwords(input logic [11:0] fft_size,
                                              input logic [15:0] max_words);
    logic [15:0] words;
    words = {4'd0, fft_size} >> 5;
    if (words == 16'd0) return 16'd1;
    if (words > max_words) return max_words;
    return words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chan_select_ram.sv
`default_nettype none
// ============================================================================
//  Module      : chan_select_ram
//  Description : Channel-select mask storage. One synchronous write port and
//                one read port whose address is registered; read data is the
//                word at the address captured on the previous clock edge.
//                Contents are intentionally not reset.
//  Ports       : clk    - clock
//                we     - write enable
//                waddr  - write address
//                wdata  - write data
//                raddr  - read address (captured every edge)
//                rdata  - word at the captured read address
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_select_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    raddr_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule
`default_nettype wire

// File: rtl/chan_select_loader.sv
`default_nettype none
// ============================================================================
//  Module      : chan_select_loader
//  Description : Collects a channel-enable mask over the settings bus and, on
//                commit, streams nwords = clamp(fft_size/32, 1, MAX_WORDS)
//                mask words to the channelizer down-selection FIFO over
//                AXI-Stream. A commit arriving during a burst is remembered
//                once and restarts streaming after the current burst ends.
//  Ports       : ce_clk / ce_rst_n          - clock, async active-low reset
//                set_stb/set_addr/set_data  - settings-bus write
//                fft_size                   - current number of channels
//                m_axis_select_*            - mask word stream
//                busy                       - loader is fetching/streaming
//                wr_drop_stb                - data write ignored while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module chan_select_loader
  import chan_select_loader_pkg::*;
#(
  parameter logic [7:0] SR_SELECT_ADDR   = CHAN_SR_SELECT_ADDR,
  parameter logic [7:0] SR_SELECT_DATA   = CHAN_SR_SELECT_DATA,
  parameter logic [7:0] SR_SELECT_COMMIT = CHAN_SR_SELECT_COMMIT,
  parameter int         MAX_WORDS        = CHAN_MAX_WORDS
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [11:0] fft_size,
  output logic [31:0] m_axis_select_tdata,
  output logic        m_axis_select_tvalid,
  output logic        m_axis_select_tlast,
  input  logic        m_axis_select_tready,
  output logic        busy,
  output logic        wr_drop_stb
);

  localparam int              AW          = $clog2(MAX_WORDS);
  localparam logic [15:0]     MAX_WORDS_W = 16'(MAX_WORDS);
  localparam logic [AW-1:0]   LAST_IDX    = AW'(MAX_WORDS - 1);

  sel_state_t     state, state_nxt;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx, rd_idx_nxt;
  logic [15:0]    nwords, nwords_nxt;
  logic           pending, pending_nxt;
  logic           commit_q;
  logic [31:0]    tdata_nxt;
  logic           tvalid_nxt, tlast_nxt;
  logic [31:0]    ram_rdata;

  logic addr_hit, data_hit, commit_hit;
  logic handshake, restart_req, mem_we;

  assign addr_hit    = set_stb && (set_addr == SR_SELECT_ADDR);
  assign data_hit    = set_stb && (set_addr == SR_SELECT_DATA);
  assign commit_hit  = set_stb && (set_addr == SR_SELECT_COMMIT);

  assign busy        = (state != ST_IDLE);
  assign handshake   = m_axis_select_tvalid && m_axis_select_tready;
  // A fresh commit and a remembered one both start (or restart) a burst.
  assign restart_req = pending || commit_q;
  assign mem_we      = data_hit && !busy;

  // --------------------------------------------------------------------------
  // Settings-bus side: write index, drop strobe, commit capture
  // --------------------------------------------------------------------------
  // The commit strobe is registered so the burst length is sampled one cycle
  // after the settings write, keeping commit-to-tvalid at two cycles.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      wr_idx      <= '0;
      wr_drop_stb <= 1'b0;
      commit_q    <= 1'b0;
    end else begin
      wr_drop_stb <= data_hit && busy;
      commit_q    <= commit_hit;
      if (addr_hit) begin
        wr_idx <= set_data[AW-1:0];
      end else if (mem_we) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + AW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Mask storage; read address follows rd_idx_nxt so the RAM output already
  // shows mem[rd_idx] while in FETCH.
  // --------------------------------------------------------------------------
  chan_select_ram #(
    .DEPTH (MAX_WORDS),
    .WIDTH (32),
    .AW    (AW)
  ) u_ram (
    .clk   (ce_clk),
    .we    (mem_we),
    .waddr (wr_idx),
    .wdata (set_data),
    .raddr (rd_idx_nxt),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (restart_req) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (handshake) begin
          state_nxt = (!m_axis_select_tlast || restart_req) ? ST_FETCH : ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    rd_idx_nxt  = rd_idx;
    nwords_nxt  = nwords;
    pending_nxt = pending;
    tdata_nxt   = m_axis_select_tdata;
    tvalid_nxt  = m_axis_select_tvalid;
    tlast_nxt   = m_axis_select_tlast;

    // Only one outstanding commit is remembered; a restart below consumes it.
    if (busy && commit_q) pending_nxt = 1'b1;

    case (state)
      ST_IDLE: begin
        tvalid_nxt = 1'b0;
        if (restart_req) begin
          rd_idx_nxt  = '0;
          nwords_nxt  = calc_nwords(fft_size, MAX_WORDS_W);
          pending_nxt = 1'b0;
        end
      end
      ST_FETCH: begin
        tdata_nxt  = ram_rdata;
        tvalid_nxt = 1'b1;
        tlast_nxt  = (16'(rd_idx) == nwords - 16'd1);
      end
      ST_STREAM: begin
        if (handshake) begin
          tvalid_nxt = 1'b0;
          if (!m_axis_select_tlast) begin
            rd_idx_nxt = rd_idx + AW'(1);
          end else if (restart_req) begin
            rd_idx_nxt  = '0;
            nwords_nxt  = calc_nwords(fft_size, MAX_WORDS_W);
            pending_nxt = 1'b0;
          end
        end
      end
      default: begin
        tvalid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      rd_idx               <= '0;
      nwords               <= 16'd1;
      pending              <= 1'b0;
      m_axis_select_tdata  <= '0;
      m_axis_select_tvalid <= 1'b0;
      m_axis_select_tlast  <= 1'b0;
    end else begin
      rd_idx               <= rd_idx_nxt;
      nwords               <= nwords_nxt;
      pending              <= pending_nxt;
      m_axis_select_tdata  <= tdata_nxt;
      m_axis_select_tvalid <= tvalid_nxt;
      m_axis_select_tlast  <= tlast_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chan_select_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chan_select_loader
//  Description : Directed self-checking bench for chan_select_loader: mask
//                writes, burst length clamping, latency, back-pressure,
//                dropped writes, commit pending and mid-burst reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chan_select_loader;

  localparam logic [7:0] A_ADDR   = 8'd134;
  localparam logic [7:0] A_DATA   = 8'd135;
  localparam logic [7:0] A_COMMIT = 8'd136;

  logic        ce_clk = 1'b0;
  logic        ce_rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [11:0] fft_size = 12'd64;
  logic [31:0] m_axis_select_tdata;
  logic        m_axis_select_tvalid;
  logic        m_axis_select_tlast;
  logic        m_axis_select_tready = 1'b0;
  logic        busy;
  logic        wr_drop_stb;

  int checks = 0;
  int failures = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];

  chan_select_loader dut (
    .ce_clk               (ce_clk),
    .ce_rst_n             (ce_rst_n),
    .set_stb              (set_stb),
    .set_addr             (set_addr),
    .set_data             (set_data),
    .fft_size             (fft_size),
    .m_axis_select_tdata  (m_axis_select_tdata),
    .m_axis_select_tvalid (m_axis_select_tvalid),
    .m_axis_select_tlast  (m_axis_select_tlast),
    .m_axis_select_tready (m_axis_select_tready),
    .busy                 (busy),
    .wr_drop_stb          (wr_drop_stb)
  );

  always #5 ce_clk = ~ce_clk;

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    tick();
    set_stb  = 1'b0;
  endtask

  // Record every handshake over a fixed window of cycles.
  task automatic collect(input int budget);
    got_data.delete();
    got_last.delete();
    for (int c = 0; c < budget; c++) begin
      if (m_axis_select_tvalid && m_axis_select_tready) begin
        got_data.push_back(m_axis_select_tdata);
        got_last.push_back(m_axis_select_tlast);
      end
      tick();
    end
  endtask

  task automatic wait_valid(output logic ok);
    int k;
    k = 0;
    while (!m_axis_select_tvalid && k < 20) begin
      tick();
      k++;
    end
    ok = m_axis_select_tvalid;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (m_axis_select_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_select_tvalid); end
    checks++; if (m_axis_select_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b expected 0", m_axis_select_tlast); end
    checks++; if (m_axis_select_tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata: got %h expected 0", m_axis_select_tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wr_drop_stb !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", wr_drop_stb); end
    ce_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_two_word();
    m_axis_select_tready = 1'b1;
    set_reg(A_ADDR, 32'd0);
    set_reg(A_DATA, 32'h0000_000F);
    set_reg(A_DATA, 32'hFFFF_0000);
    fft_size = 12'd64;
    set_reg(A_COMMIT, 32'd0);
    checks++; if (m_axis_select_tvalid !== 1'b0) begin failures++; $display("FAIL lat_n0: tvalid got %b expected 0", m_axis_select_tvalid); end
    tick();
    checks++; if (m_axis_select_tvalid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL lat_n1: tvalid/busy got %b/%b expected 0/1", m_axis_select_tvalid, busy); end
    tick();
    checks++; if (m_axis_select_tvalid !== 1'b1) begin failures++; $display("FAIL lat_n2: tvalid got %b expected 1", m_axis_select_tvalid); end
    collect(20);
    checks++; if (got_data.size() !== 2) begin failures++; $display("FAIL two_count: got %0d expected 2", got_data.size()); end
    checks++; if (got_data[0] !== 32'h0000_000F || got_last[0] !== 1'b0) begin failures++; $display("FAIL two_w0: got %h/%b expected 0000000f/0", got_data[0], got_last[0]); end
    checks++; if (got_data[1] !== 32'hFFFF_0000 || got_last[1] !== 1'b1) begin failures++; $display("FAIL two_w1: got %h/%b expected ffff0000/1", got_data[1], got_last[1]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL two_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_min_size();
    fft_size = 12'd16;
    set_reg(A_COMMIT, 32'd0);
    collect(20);
    checks++; if (got_data.size() !== 1) begin failures++; $display("FAIL min_count: got %0d expected 1", got_data.size()); end
    checks++; if (got_data[0] !== 32'h0000_000F) begin failures++; $display("FAIL min_data: got %h expected 0000000f", got_data[0]); end
    checks++; if (got_last[0] !== 1'b1) begin failures++; $display("FAIL min_last: got %b expected 1", got_last[0]); end
  endtask

  task automatic test_full_and_wrap();
    int bad;
    int lastbad;
    logic [31:0] exp;
    set_reg(A_ADDR, 32'd0);
    for (int i = 0; i < 64; i++) set_reg(A_DATA, pat(i));
    // Index has wrapped from 63 to 0: this lands in word 0.
    set_reg(A_DATA, 32'hDEAD_BEEF);
    fft_size = 12'd4095;
    set_reg(A_COMMIT, 32'd0);
    collect(200);
    checks++; if (got_data.size() !== 64) begin failures++; $display("FAIL full_count: got %0d expected 64", got_data.size()); end
    bad = 0;
    lastbad = 0;
    for (int i = 0; i < 64; i++) begin
      exp = (i == 0) ? 32'hDEAD_BEEF : pat(i);
      if (got_data[i] !== exp) bad++;
      if (got_last[i] !== (i == 63)) lastbad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_data: got %0d bad words expected 0 (word0 %h expected deadbeef)", bad, got_data[0]); end
    checks++; if (lastbad !== 0) begin failures++; $display("FAIL full_last: got %0d misplaced tlast expected 0", lastbad); end
  endtask

  task automatic test_backpressure();
    logic ok;
    logic [31:0] first;
    logic [31:0] held;
    logic held_last;
    int bad;
    fft_size = 12'd128;
    m_axis_select_tready = 1'b1;
    set_reg(A_COMMIT, 32'd0);
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_wait: tvalid got %b expected 1", ok); end
    first = m_axis_select_tdata;
    tick();
    m_axis_select_tready = 1'b0;
    tick();
    held = m_axis_select_tdata;
    held_last = m_axis_select_tlast;
    fft_size = 12'd16;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== held || m_axis_select_tlast !== held_last) bad++;
    end
    m_axis_select_tready = 1'b1;
    collect(20);
    checks++; if (first !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_first: got %h expected deadbeef", first); end
    checks++; if (held !== pat(1) || held_last !== 1'b0) begin failures++; $display("FAIL bp_held: got %h/%b expected %h/0", held, held_last, pat(1)); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    checks++; if (got_data.size() !== 3) begin failures++; $display("FAIL bp_count: got %0d expected 3", got_data.size()); end
    checks++; if (got_data[0] !== pat(1) || got_data[2] !== pat(3)) begin failures++; $display("FAIL bp_words: got %h,%h expected %h,%h", got_data[0], got_data[2], pat(1), pat(3)); end
    checks++; if (got_last[2] !== 1'b1 || got_last[1] !== 1'b0) begin failures++; $display("FAIL bp_last: got %b%b expected 01", got_last[1], got_last[2]); end
  endtask

  task automatic test_drop();
    logic ok;
    int extra;
    fft_size = 12'd64;
    m_axis_select_tready = 1'b0;
    set_reg(A_COMMIT, 32'd0);
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL drop_wait: tvalid got %b expected 1", ok); end
    set_reg(A_DATA, 32'h1234_5678);
    checks++; if (wr_drop_stb !== 1'b1) begin failures++; $display("FAIL drop_pulse: got %b expected 1", wr_drop_stb); end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_drop_stb !== 1'b0) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL drop_once: got %0d extra pulse cycles expected 0", extra); end
    m_axis_select_tready = 1'b1;
    collect(20);
    checks++; if (got_data.size() !== 2 || got_data[1] !== pat(1)) begin failures++; $display("FAIL drop_mem: got %0d words, w1 %h expected 2, %h", got_data.size(), got_data[1], pat(1)); end
    // The index must not have moved: this write goes to word 1.
    set_reg(A_DATA, 32'hCAFE_F00D);
    set_reg(A_COMMIT, 32'd0);
    collect(20);
    checks++; if (got_data[0] !== 32'hDEAD_BEEF || got_data[1] !== 32'hCAFE_F00D) begin failures++; $display("FAIL drop_idx: got %h,%h expected deadbeef,cafef00d", got_data[0], got_data[1]); end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [31:0] exp_d [4];
    logic        exp_l [4];
    exp_d = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    fft_size = 12'd64;
    m_axis_select_tready = 1'b0;
    set_reg(A_COMMIT, 32'd0);
    tick();
    set_reg(A_COMMIT, 32'd0);
    set_reg(A_COMMIT, 32'd0);
    m_axis_select_tready = 1'b1;
    collect(40);
    checks++; if (got_data.size() !== 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", got_data.size()); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_words: got %0d bad words expected 0", bad); end
    checks++; if (busy !== 1'b0 || m_axis_select_tvalid !== 1'b0) begin failures++; $display("FAIL b2b_idle: busy/tvalid got %b/%b expected 0/0", busy, m_axis_select_tvalid); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    fft_size = 12'd64;
    m_axis_select_tready = 1'b0;
    set_reg(A_COMMIT, 32'd0);
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_wait: tvalid got %b expected 1", ok); end
    set_reg(A_COMMIT, 32'd0);
    #2;
    ce_rst_n = 1'b0;
    #1;
    checks++; if (m_axis_select_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid: got %b expected 0", m_axis_select_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    tick();
    tick();
    ce_rst_n = 1'b1;
    m_axis_select_tready = 1'b1;
    collect(30);
    checks++; if (got_data.size() !== 0) begin failures++; $display("FAIL rstmid_resume: got %0d words expected 0", got_data.size()); end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_min_size();
    test_full_and_wrap();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
